// File: rtl/in_service_control.sv
`default_nettype none
// ============================================================================
//  Module      : in_service_control
//  Description : In-Service Register (ISR) control stage of the 8259A
//                interrupt controller, downstream of the priority resolver.
//                Latches the resolver's one-hot grant into the ISR during the
//                INTA sequence. Executes specific and non-specific EOI,
//                rotate-on-EOI and set-priority commands. Feeds the ISR, the
//                highest in-service level and the rotation back to the
//                resolver.
//
//  Ports       : clock                    - system clock, rising edge
//                reset_n                  - synchronous active-low reset
//                interrupt[7:0]           - one-hot grant from resolver
//                inta_first               - strobe, first INTA pulse
//                inta_second              - strobe, end of second INTA pulse
//                eoi_nonspecific          - strobe, non-specific EOI
//                eoi_specific             - strobe, specific EOI at eoi_level
//                eoi_level[2:0]           - EOI / set-priority target level
//                rotate_on_eoi            - turns either EOI into rotate-on-EOI
//                set_priority             - strobe, priority_rotate <= eoi_level
//                auto_eoi_config          - AEOI mode select
//                in_service_register[7:0] - ISR
//                highest_level_in_service - one-hot top ISR bit under rotation
//                priority_rotate[2:0]     - current lowest-priority level
//                ack_level[2:0]           - level latched on inta_first
//                spurious                 - acknowledge found no request
//
//  Options     : IN_SERVICE_AUTO_EOI_EN - when defined, auto_eoi_config=1
//                clears the acknowledged ISR bit at the end of the second
//                INTA pulse. When undefined, auto_eoi_config is ignored.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module in_service_control #(
    parameter logic [2:0] RESET_ROTATE = 3'b111
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt,
    input  logic       inta_first,
    input  logic       inta_second,
    input  logic       eoi_nonspecific,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       rotate_on_eoi,
    input  logic       set_priority,
    input  logic       auto_eoi_config,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic [2:0] ack_level,
    output logic       spurious
);

    // ------------------------------------------------------------------
    // Acknowledge sequencer
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK2 = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_isr;
    logic [2:0] r_rotate;
    logic [2:0] r_ack_level;
    logic       r_spurious;

    logic       w_ack_accept;
    logic       w_ack_finish;

    // A second inta_first inside ACK2 and a stray inta_second in IDLE are
    // both ignored. The transitions below only ever react to the strobe
    // that is legal in the current state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (inta_first)  w_state_next = ST_ACK2;
            ST_ACK2: if (inta_second) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_ack_accept = (r_state == ST_IDLE) && inta_first;
    assign w_ack_finish = (r_state == ST_ACK2) && inta_second;

    // ------------------------------------------------------------------
    // Binary index of the lowest set grant bit. An empty grant encodes
    // as 7, which is the level reported for a spurious acknowledge.
    // ------------------------------------------------------------------
    logic [2:0] w_grant_level;

    always_comb begin
        w_grant_level = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (interrupt[i]) w_grant_level = i[2:0];
        end
    end

    // ------------------------------------------------------------------
    // Highest-priority in-service level under the current rotation.
    // priority_rotate names the lowest-priority level, so the search
    // starts one above it and wraps around, ending on the rotate level.
    // ------------------------------------------------------------------
    logic [7:0] w_highest;
    logic [2:0] w_highest_idx;
    logic       w_highest_valid;
    logic [2:0] w_search_level;

    always_comb begin
        w_highest       = 8'h00;
        w_highest_idx   = 3'd0;
        w_highest_valid = 1'b0;
        w_search_level  = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            w_search_level = r_rotate + i[2:0];
            if (!w_highest_valid && r_isr[w_search_level]) begin
                w_highest_valid = 1'b1;
                w_highest_idx   = w_search_level;
            end
        end
        if (w_highest_valid) w_highest = 8'b1 << w_highest_idx;
    end

    // ------------------------------------------------------------------
    // EOI decode. Both flavours work on the ISR as it stands this cycle.
    // Specific EOI takes precedence when both strobes coincide. A rotating
    // specific EOI always moves the rotation to eoi_level, as the command
    // names its level explicitly. A rotating non-specific EOI only rotates
    // when there was something in service to retire.
    // ------------------------------------------------------------------
    logic [7:0] w_eoi_clear;
    logic [2:0] w_eoi_target;
    logic       w_eoi_rotate;

    always_comb begin
        w_eoi_clear  = 8'h00;
        w_eoi_target = 3'd0;
        w_eoi_rotate = 1'b0;
        if (eoi_specific) begin
            w_eoi_clear  = 8'b1 << eoi_level;
            w_eoi_target = eoi_level;
            w_eoi_rotate = rotate_on_eoi;
        end else if (eoi_nonspecific && w_highest_valid) begin
            w_eoi_clear  = w_highest;
            w_eoi_target = w_highest_idx;
            w_eoi_rotate = rotate_on_eoi;
        end
    end

    // ------------------------------------------------------------------
    // Automatic EOI at the end of the acknowledge sequence
    // ------------------------------------------------------------------
    logic       w_auto_eoi;
    logic [7:0] w_auto_clear;

`ifdef IN_SERVICE_AUTO_EOI_EN
    // A spurious acknowledge never set a bit, so there is nothing to retire.
    assign w_auto_eoi   = w_ack_finish && auto_eoi_config && !r_spurious;
    assign w_auto_clear = w_auto_eoi ? (8'b1 << r_ack_level) : 8'h00;
`else
    assign w_auto_eoi   = 1'b0;
    assign w_auto_clear = 8'h00;

    // The mode input stays on the port list so both builds share a pinout.
    logic w_unused_auto_eoi_config;
    assign w_unused_auto_eoi_config = auto_eoi_config;
`endif

    // ------------------------------------------------------------------
    // Next ISR and rotation
    // ------------------------------------------------------------------
    logic [7:0] w_isr_set;
    logic [7:0] w_isr_next;
    logic [2:0] w_rotate_next;

    // A bit being granted in the same cycle as its EOI stays set, because
    // the grant belongs to a fresh acknowledge.
    assign w_isr_set  = w_ack_accept ? interrupt : 8'h00;
    assign w_isr_next = (r_isr & ~(w_eoi_clear | w_auto_clear)) | w_isr_set;

    // Later assignments take precedence: set_priority over an explicit
    // rotating EOI, and an explicit rotating EOI over an automatic one.
    always_comb begin
        w_rotate_next = r_rotate;
        if (w_auto_eoi && rotate_on_eoi) w_rotate_next = r_ack_level;
        if (w_eoi_rotate)                w_rotate_next = w_eoi_target;
        if (set_priority)                w_rotate_next = eoi_level;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_isr       <= 8'h00;
            r_rotate    <= RESET_ROTATE;
            r_ack_level <= 3'd0;
            r_spurious  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_isr    <= w_isr_next;
            r_rotate <= w_rotate_next;
            if (w_ack_accept) begin
                r_ack_level <= w_grant_level;
                r_spurious  <= (interrupt == 8'h00);
            end else if (w_ack_finish) begin
                r_spurious  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_service_register      = r_isr;
    assign highest_level_in_service = w_highest;
    assign priority_rotate          = r_rotate;
    assign ack_level                = r_ack_level;
    assign spurious                 = r_spurious;

endmodule
`default_nettype wire
